// File: rtl/mmram_merge_arb.sv
// Two-into-one packet merge arbiter for Send/Ack token streams: one requester owns the
// single-word output register for PKT_LEN words, then ownership alternates round-robin.
module mmram_merge_arb #(
    parameter int DW      = 32,
    parameter int PKT_LEN = 2,
    parameter int CW      = $clog2(PKT_LEN + 1)
) (
    input  logic          cp,
    input  logic          MR,
    input  logic          Send_in0,
    input  logic [DW-1:0] Data_in0,
    output logic          Ack_out0,
    input  logic          Send_in1,
    input  logic [DW-1:0] Data_in1,
    output logic          Ack_out1,
    output logic          Send_out,
    output logic [DW-1:0] Data_out,
    input  logic          Ack_in,
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state;
    logic          prio;
    logic [CW-1:0] cnt;
    logic          can_load;
    logic          xfer0;
    logic          xfer1;
    logic          last;

    // The output register may take a word when empty or when it drains this same edge.
    assign can_load = ~Send_out | Ack_in;
    assign Ack_out0 = (state == G0) && can_load;
    assign Ack_out1 = (state == G1) && can_load;
    assign xfer0    = Send_in0 & Ack_out0;
    assign xfer1    = Send_in1 & Ack_out1;
    assign last     = (cnt == CW'(PKT_LEN - 1));
    assign grant    = {state == G1, state == G0};
    assign busy     = (state != IDLE);

    always_ff @(posedge cp or posedge MR) begin
        if (MR) begin
            state    <= IDLE;
            prio     <= 1'b0;
            cnt      <= '0;
            Send_out <= 1'b0;
            Data_out <= '0;
        end else if (xfer0 || xfer1) begin
            Send_out <= 1'b1;
            Data_out <= xfer1 ? Data_in1 : Data_in0;
            if (last) begin
                // Packet complete: release and favour the other requester next time.
                state <= IDLE;
                cnt   <= '0;
                prio  <= xfer0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            if (Ack_in)
                Send_out <= 1'b0;
            if (state == IDLE) begin
                if (Send_in0 && (!Send_in1 || !prio))
                    state <= G0;
                else if (Send_in1)
                    state <= G1;
            end
        end
    end

endmodule
